// File: rtl/lp_alu_pkg.sv
// Shared definitions for the sequential low-power ALU: op encodings, FSM states
// and a small op-classification helper.
package lp_alu_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic is_shift_op(input logic [OP_W-1:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/lp_alu_if.sv
// Operand/result handshake bundle between an ALU client (master) and the ALU (slave).
interface lp_alu_if #(
    parameter int WIDTH = 32
);
    import lp_alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;
    logic             illegal;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, carry, overflow, zero, negative, illegal
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, carry, overflow, zero, negative, illegal
    );

endinterface

// File: rtl/lp_alu_shift_step.sv
// Combinational shift by 0..STEP positions, left (zero fill) or right (fill bit),
// also returning the last bit shifted out (0 when amt is 0).
module lp_alu_shift_step #(
    parameter  int WIDTH = 32,
    parameter  int STEP  = 4,
    localparam int AMT_W = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] amt,
    input  logic             left,
    input  logic             fill,
    output logic [WIDTH-1:0] data_out,
    output logic             out_bit
);

    logic [WIDTH-1:0] cand_l [1:STEP];
    logic [WIDTH-1:0] cand_r [1:STEP];
    logic [STEP:1]    bit_l;
    logic [STEP:1]    bit_r;

    for (genvar gi = 1; gi <= STEP; gi++) begin : g_amt
        if (gi < WIDTH) begin : g_part
            assign cand_l[gi] = {data[WIDTH-1-gi:0], {gi{1'b0}}};
            assign cand_r[gi] = {{gi{fill}}, data[WIDTH-1:gi]};
        end else begin : g_full
            assign cand_l[gi] = '0;
            assign cand_r[gi] = {WIDTH{fill}};
        end
        assign bit_l[gi] = data[WIDTH-gi];
        assign bit_r[gi] = data[gi-1];
    end

    always_comb begin
        data_out = data;
        out_bit  = 1'b0;
        for (int k = 1; k <= STEP; k++) begin
            if (amt == AMT_W'(k)) begin
                data_out = left ? cand_l[k] : cand_r[k];
                out_bit  = left ? bit_l[k]  : bit_r[k];
            end
        end
    end

endmodule

// File: rtl/lp_alu_seq.sv
// Sequential RV32I-style ALU with valid/ready on both sides; shifts iterate through
// one STEP-bit shifter, everything else completes on the accept edge.
module lp_alu_seq
    import lp_alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int STEP  = 4,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic   clk,
    input  logic   rst_n,
    lp_alu_if.slave bus
);

    localparam int            AMT_W  = $clog2(STEP + 1);
    localparam logic [SHW:0]  STEP_X = (SHW + 1)'(STEP);

    state_e           state_reg, state_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             carry_reg, carry_next;
    logic             overflow_reg, overflow_next;
    logic             illegal_reg, illegal_next;
    logic             zero_reg, negative_reg;
    logic [SHW:0]     rem_reg, rem_next;
    logic             left_reg, left_next;
    logic             fill_reg, fill_next;
    logic             load;
    logic             in_ready;
    logic             accept;
    logic             start_shift;
    logic [SHW-1:0]   shamt;

    // One WIDTH+1 adder shared by ADD and SUB (SUB = a + ~b + 1).
    logic             is_sub;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum;
    logic             add_ovf;

    assign is_sub  = (bus.op == OP_SUB);
    assign b_op    = is_sub ? ~bus.b : bus.b;
    assign sum     = {1'b0, bus.a} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
    assign add_ovf = (bus.a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
    assign shamt   = bus.b[SHW-1:0];

    // Per-cycle shift distance is min(STEP, rem); the working value lives in result_reg.
    logic [SHW:0]     step_x;
    logic [SHW:0]     rem_step;
    logic [AMT_W-1:0] step_amt;
    logic [WIDTH-1:0] step_data;
    logic             step_bit;

    assign step_x   = (rem_reg >= STEP_X) ? STEP_X : rem_reg;
    assign rem_step = rem_reg - step_x;
    assign step_amt = AMT_W'(step_x);

    lp_alu_shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_shift_step (
        .data     (result_reg),
        .amt      (step_amt),
        .left     (left_reg),
        .fill     (fill_reg),
        .data_out (step_data),
        .out_bit  (step_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        in_ready    = 1'b0;
        case (state_reg)
            ST_IDLE: in_ready = 1'b1;
            ST_DONE: in_ready = bus.out_ready;
            default: in_ready = 1'b0;
        endcase
        accept      = bus.in_valid && in_ready;
        start_shift = is_shift_op(bus.op) && (shamt != '0);
        case (state_reg)
            ST_IDLE: begin
                if (accept) state_next = start_shift ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                if (rem_step == '0) state_next = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    if (accept) state_next = start_shift ? ST_SHIFT : ST_DONE;
                    else        state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        load          = 1'b0;
        result_next   = result_reg;
        carry_next    = carry_reg;
        overflow_next = 1'b0;
        illegal_next  = 1'b0;
        rem_next      = rem_reg;
        left_next     = left_reg;
        fill_next     = fill_reg;
        if (accept) begin
            load       = 1'b1;
            carry_next = 1'b0;
            case (bus.op)
                OP_ADD: begin
                    result_next   = sum[WIDTH-1:0];
                    carry_next    = sum[WIDTH];
                    overflow_next = add_ovf;
                end
                OP_SUB: begin
                    result_next   = sum[WIDTH-1:0];
                    carry_next    = ~sum[WIDTH];
                    overflow_next = add_ovf;
                end
                OP_AND:  result_next = bus.a & bus.b;
                OP_OR:   result_next = bus.a | bus.b;
                OP_XOR:  result_next = bus.a ^ bus.b;
                OP_SLL, OP_SRL, OP_SRA: begin
                    // shamt == 0 finishes here with result = a and carry = 0.
                    result_next = bus.a;
                    rem_next    = {1'b0, shamt};
                    left_next   = (bus.op == OP_SLL);
                    fill_next   = (bus.op == OP_SRA) && bus.a[WIDTH-1];
                end
                OP_SLT:  result_next = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
                OP_SLTU: result_next = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
                default: begin
                    result_next  = '0;
                    illegal_next = 1'b1;
                end
            endcase
        end else if (state_reg == ST_SHIFT) begin
            load        = 1'b1;
            result_next = step_data;
            carry_next  = step_bit;
            rem_next    = rem_step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg   <= '0;
            carry_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            illegal_reg  <= 1'b0;
            zero_reg     <= 1'b0;
            negative_reg <= 1'b0;
            rem_reg      <= '0;
            left_reg     <= 1'b0;
            fill_reg     <= 1'b0;
        end else if (load) begin
            result_reg   <= result_next;
            carry_reg    <= carry_next;
            overflow_reg <= overflow_next;
            illegal_reg  <= illegal_next;
            zero_reg     <= (result_next == '0);
            negative_reg <= result_next[WIDTH-1];
            rem_reg      <= rem_next;
            left_reg     <= left_next;
            fill_reg     <= fill_next;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_reg == ST_DONE);
    assign bus.result    = result_reg;
    assign bus.carry     = carry_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.zero      = zero_reg;
    assign bus.negative  = negative_reg;
    assign bus.illegal   = illegal_reg;

endmodule

// File: doc/lp_alu_seq.md
Name: lp_alu_seq

Overview:
- Parametrised successor to the team's 4-bit combinational ALU, aimed at the low-power RISC-V datapath.
- Executes the RV32I integer ops (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU) at configurable WIDTH.
- Uses a valid/ready handshake on both sides. Operand registers load only on an accepted transfer, which isolates the operands and cuts switching.
- Shifts run through one shared STEP-bit shifter over several cycles instead of a full barrel shifter.

Parameters:
- WIDTH, 32: operand/result width; power of two, at least 8.
- STEP, 4: maximum shift distance per cycle; power of two, 1 to WIDTH.
- SHW, log2(WIDTH): shift-amount width; derived, not overridable.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- in_valid, input, 1: operand/op presented.
- in_ready, output, 1: block can accept a new operation.
- op, input, 4: operation code (encodings in package).
- a, input, WIDTH: operand A.
- b, input, WIDTH: operand B; for shifts, b[SHW-1:0] is the shift amount.
- out_valid, output, 1: result and flags valid.
- out_ready, input, 1: consumer accepts the result.
- result, output, WIDTH: registered result.
- carry, output, 1: ADD carry-out; SUB borrow (1 when a < b unsigned); shifts give the last bit shifted out; 0 for all other ops.
- overflow, output, 1: signed overflow for ADD/SUB; 0 otherwise.
- zero, output, 1: result == 0.
- negative, output, 1: result[WIDTH-1].
- illegal, output, 1: op is not a defined encoding.

Behaviour:
- Reset:
  - State goes to IDLE.
  - out_valid, result, carry, overflow, zero, negative and illegal all go to 0.
  - in_ready is 1 once reset deasserts.
  - A reset mid-shift or mid-hold aborts the operation; no result is produced.
- States are IDLE, SHIFT and DONE.
- Accept: an operation is accepted on a rising edge with in_valid && in_ready.
- in_ready is 1 in IDLE, and 1 in DONE when out_ready is 1, which allows back-to-back operations. It is 0 in SHIFT.
- Non-shift op accepted:
  - Result and flags are computed and registered on the accept edge; state goes to DONE.
  - Latency is 1 edge.
- Shift op accepted with shamt == 0:
  - result = a, carry = 0; state goes to DONE; latency is 1 edge.
- Shift op accepted with shamt > 0:
  - The accept edge loads the working register with a and the remaining count rem with shamt; state goes to SHIFT.
  - Each SHIFT edge shifts by min(STEP, rem) and subtracts the same amount from rem.
  - When rem reaches 0 on an edge, state goes to DONE on that same edge.
  - Total latency is 1 + ceil(shamt/STEP) edges.
  - SLL and SRL fill with 0; SRA fills with the original a[WIDTH-1].
  - carry is the last bit shifted out.
- DONE:
  - out_valid = 1.
  - If out_ready = 1, the result is consumed. A simultaneous accept starts the next operation; otherwise state goes to IDLE and out_valid drops.
  - If out_ready = 0, result and all flags hold stable and in_ready = 0.
- Arithmetic:
  - ADD/SUB use a single shared WIDTH+1 adder; SUB is a + ~b + 1, with borrow = ~carry_out.
  - SLT is a signed compare and SLTU an unsigned compare; both give result 0 or 1 with carry = 0 and overflow = 0.
  - Logic ops give overflow = 0 and carry = 0.
  - zero and negative are always derived from the registered result.
- Illegal op:
  - It is accepted normally: result = 0, illegal = 1, zero = 1, latency 1.
  - illegal is 0 for every defined op.
- No combinational path from in_valid, a or b to any output. in_ready depends combinationally only on state and out_ready.

Decomposition:
- Package lp_alu_pkg holds:
  - the op encodings: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9; 10 to 15 are illegal;
  - the OP_W=4 constant;
  - the state enumeration.
- One sub-module, lp_alu_shift_step: combinational shift by 0..STEP with the fill bit and shifted-out bit. It is instantiated once and reused on every SHIFT cycle.

Test Plan:
- All tests use WIDTH=32, STEP=4.
- ADD a=0xFFFFFFFF, b=1, out_ready=1 -> after 1 edge: result 0x00000000, carry 1, zero 1, overflow 0, out_valid 1.
- SUB a=0x80000000, b=1 -> result 0x7FFFFFFF, overflow 1, carry 0, negative 0; then SLTU a=1, b=2 -> result 1.
- SLL a=0x00000001, b=9 -> in_ready 0 for 3 SHIFT cycles; out_valid after the 4th edge; result 0x00000200, carry 0.
- SRA a=0x80000000, b=4 -> result 0xF8000000, negative 1, latency 2 edges; SRL with the same operands -> result 0x08000000.
- Backpressure: hold out_ready=0 for 5 cycles after the XOR a=0xF0F0F0F0, b=0xFF00FF00 result 0x0FF00FF0 -> result, flags and out_valid stable, in_ready 0. Then raise out_ready with in_valid high and op AND -> back-to-back accept, no bubble.
- Reset and illegal op: assert rst_n=0 during an SLL with b=31 mid-SHIFT -> out_valid 0, result 0, in_ready 1 after release. Then op=12 -> illegal 1, result 0, zero 1.
